// File: rtl/rx_op_buffer.sv
// rx_op_buffer
//   Captures op_ids from the rx mux into a small first-word-fall-through FIFO.
//   Each stored entry is tagged with the switch index that produced it.
//   A write request is any cycle in which the delayed ack vector (sel) has
//   exactly one bit set. A sel with several bits set is dropped and flagged.
//   The consumer pops the head entry with rd_en.
//
// Ports
//   clk        in   single clock; all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   sel        in   delayed ack vector, one bit per switch instance
//   op_id_in   in   rx mux output, valid in the same cycle as sel
//   rd_en      in   pop request; ignored while the FIFO is empty
//   err_clr    in   clears the sticky error flags
//   op_id_out  out  head op_id, 0 while empty
//   src_idx    out  head switch index, 0 while empty
//   op_vld     out  FIFO not empty
//   full       out  count == DEPTH
//   count      out  occupancy
//   ovf_err    out  sticky: a write was dropped while full
//   multi_err  out  sticky: more than one sel bit was set
module rx_op_buffer #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int DEPTH       = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SW_INST-1:0]         sel,
    input  logic [W_WIDTH-1:0]             op_id_in,
    input  logic                           rd_en,
    input  logic                           err_clr,
    output logic [W_WIDTH-1:0]             op_id_out,
    output logic [$clog2(NUM_SW_INST)-1:0] src_idx,
    output logic                           op_vld,
    output logic                           full,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           ovf_err,
    output logic                           multi_err
);

    localparam int SEL_W = $clog2(NUM_SW_INST);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = SEL_W + W_WIDTH;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] head;

    logic             sel_multi;
    logic             wr_req;
    logic             pop;
    logic             wr_acc;
    logic             ovf_set;
    logic [SEL_W-1:0] wr_idx;

    // Clearing the lowest set bit leaves something only when two or more
    // bits were set.
    assign sel_multi = |(sel & (sel - NUM_SW_INST'(1)));
    assign wr_req    = (sel != '0) && !sel_multi;

    always_comb begin
        wr_idx = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (sel[i]) wr_idx = SEL_W'(i);
        end
    end

    assign op_vld  = (count != '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign pop     = rd_en && op_vld;
    // A pop in the same cycle frees the slot that the write lands in.
    assign wr_acc  = wr_req && (!full || pop);
    assign ovf_set = wr_req && full && !pop;

    // Storage is not reset; the output gating keeps stale data hidden.
    assign head      = mem[rd_ptr];
    assign op_id_out = op_vld ? head[W_WIDTH-1:0]     : '0;
    assign src_idx   = op_vld ? head[ENT_W-1:W_WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= {wr_idx, op_id_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_acc && !pop)      count <= count + CNT_W'(1);
            else if (pop && !wr_acc) count <= count - CNT_W'(1);
        end
    end

    // A set condition in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err   <= 1'b0;
            multi_err <= 1'b0;
        end else begin
            if (ovf_set)      ovf_err <= 1'b1;
            else if (err_clr) ovf_err <= 1'b0;

            if (sel_multi)    multi_err <= 1'b1;
            else if (err_clr) multi_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_op_buffer.sv
module tb_rx_op_buffer;

    logic       clk;
    logic       rst_n;
    logic [4:0] sel;
    logic [7:0] op_id_in;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] op_id_out;
    logic [2:0] src_idx;
    logic       op_vld;
    logic       full;
    logic [2:0] count;
    logic       ovf_err;
    logic       multi_err;

    int checks   = 0;
    int failures = 0;

    rx_op_buffer #(.NUM_SW_INST(5), .W_WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .op_id_in  (op_id_in),
        .rd_en     (rd_en),
        .err_clr   (err_clr),
        .op_id_out (op_id_out),
        .src_idx   (src_idx),
        .op_vld    (op_vld),
        .full      (full),
        .count     (count),
        .ovf_err   (ovf_err),
        .multi_err (multi_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; sel = 5'b00100; op_id_in = 8'h99; rd_en = 1'b1; err_clr = 1'b0;
        #22;
        checks++;
        if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++;
        if (op_vld !== 1'b0) begin failures++; $display("FAIL reset_op_vld got=%b exp=0", op_vld); end
        checks++;
        if ({op_id_out, src_idx, full, ovf_err, multi_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got op=%h src=%0d full=%b ovf=%b multi=%b exp all 0",
                     op_id_out, src_idx, full, ovf_err, multi_err);
        end
        sel = 5'b00000; rd_en = 1'b0; op_id_in = 8'h00;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_single_write;
        sel = 5'b00100; op_id_in = 8'hA5;
        tick;
        sel = 5'b00000;
        checks++;
        if ({op_vld, op_id_out, src_idx, count} !== {1'b1, 8'hA5, 3'd2, 3'd1}) begin
            failures++;
            $display("FAIL single_write got vld=%b op=%h src=%0d cnt=%0d exp vld=1 op=a5 src=2 cnt=1",
                     op_vld, op_id_out, src_idx, count);
        end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        checks++;
        if ({op_vld, op_id_out, src_idx, count} !== 15'd0) begin
            failures++;
            $display("FAIL single_pop got vld=%b op=%h src=%0d cnt=%0d exp all 0",
                     op_vld, op_id_out, src_idx, count);
        end
    endtask

    task automatic test_fill_overflow;
        for (int i = 1; i <= 5; i++) begin
            sel = 5'(1 << ((i - 1) % 5));
            op_id_in = 8'(i);
            tick;
        end
        sel = 5'b00000;
        checks++;
        if ({full, count, ovf_err} !== {1'b1, 3'd4, 1'b1}) begin
            failures++;
            $display("FAIL fill_ovf got full=%b cnt=%0d ovf=%b exp full=1 cnt=4 ovf=1", full, count, ovf_err);
        end
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if ({op_vld, op_id_out, src_idx} !== {1'b1, 8'(i), 3'(i - 1)}) begin
                failures++;
                $display("FAIL fill_drain_%0d got vld=%b op=%h src=%0d exp vld=1 op=%h src=%0d",
                         i, op_vld, op_id_out, src_idx, 8'(i), i - 1);
            end
            rd_en = 1'b1;
            tick;
            rd_en = 1'b0;
        end
        checks++;
        if ({count, op_vld, ovf_err} !== {3'd0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL fill_after_drain got cnt=%0d vld=%b ovf=%b exp cnt=0 vld=0 ovf=1", count, op_vld, ovf_err);
        end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        checks++;
        if (ovf_err !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf_err); end
    endtask

    task automatic test_multi_ack;
        sel = 5'b10010; op_id_in = 8'h3C;
        tick;
        sel = 5'b00000;
        checks++;
        if ({count, op_vld, multi_err, ovf_err} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL multi_ack got cnt=%0d vld=%b multi=%b ovf=%b exp cnt=0 vld=0 multi=1 ovf=0",
                     count, op_vld, multi_err, ovf_err);
        end
        err_clr = 1'b1;
        tick;
        checks++;
        if (multi_err !== 1'b0) begin failures++; $display("FAIL multi_clear got=%b exp=0", multi_err); end
        sel = 5'b00011;
        tick;
        sel = 5'b00000; err_clr = 1'b0;
        checks++;
        if ({multi_err, count} !== {1'b1, 3'd0}) begin
            failures++;
            $display("FAIL multi_set_wins got multi=%b cnt=%0d exp multi=1 cnt=0", multi_err, count);
        end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
    endtask

    task automatic test_full_rw;
        for (int i = 1; i <= 4; i++) begin
            sel = 5'b00001; op_id_in = 8'(i);
            tick;
        end
        rd_en = 1'b1; sel = 5'b00001; op_id_in = 8'hEE;
        tick;
        rd_en = 1'b0; sel = 5'b00000;
        checks++;
        if ({count, full, ovf_err} !== {3'd4, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL full_rw got cnt=%0d full=%b ovf=%b exp cnt=4 full=1 ovf=0", count, full, ovf_err);
        end
        begin
            logic [7:0] exp_q [4];
            exp_q = '{8'h02, 8'h03, 8'h04, 8'hEE};
            for (int i = 0; i < 4; i++) begin
                checks++;
                if ({op_vld, op_id_out} !== {1'b1, exp_q[i]}) begin
                    failures++;
                    $display("FAIL full_rw_drain_%0d got vld=%b op=%h exp vld=1 op=%h", i, op_vld, op_id_out, exp_q[i]);
                end
                rd_en = 1'b1;
                tick;
                rd_en = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        sel = 5'b01000; op_id_in = 8'h11;
        tick;
        sel = 5'b10000; op_id_in = 8'h22; rd_en = 1'b1;
        tick;
        sel = 5'b00000; rd_en = 1'b0;
        checks++;
        if ({count, op_id_out, src_idx} !== {3'd1, 8'h22, 3'd4}) begin
            failures++;
            $display("FAIL rw_count1 got cnt=%0d op=%h src=%0d exp cnt=1 op=22 src=4", count, op_id_out, src_idx);
        end
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
    endtask

    task automatic test_read_empty;
        rd_en = 1'b1;
        tick;
        tick;
        rd_en = 1'b0;
        checks++;
        if ({count, op_vld, op_id_out, ovf_err, multi_err} !== 13'd0) begin
            failures++;
            $display("FAIL read_empty got cnt=%0d vld=%b op=%h ovf=%b multi=%b exp all 0",
                     count, op_vld, op_id_out, ovf_err, multi_err);
        end
    endtask

    task automatic test_reset_mid;
        sel = 5'b00010; op_id_in = 8'h41; tick;
        sel = 5'b01000; op_id_in = 8'h42; tick;
        sel = 5'b10000; op_id_in = 8'h43; tick;
        sel = 5'b00110; tick;
        sel = 5'b00000;
        checks++;
        if ({count, multi_err} !== {3'd3, 1'b1}) begin
            failures++;
            $display("FAIL mid_pre got cnt=%0d multi=%b exp cnt=3 multi=1", count, multi_err);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({count, op_vld, full, op_id_out, src_idx, ovf_err, multi_err} !== 17'd0) begin
            failures++;
            $display("FAIL mid_reset got cnt=%0d vld=%b full=%b op=%h src=%0d ovf=%b multi=%b exp all 0",
                     count, op_vld, full, op_id_out, src_idx, ovf_err, multi_err);
        end
        sel = 5'b00010; op_id_in = 8'h77;
        #2 rst_n = 1'b1;
        tick;
        sel = 5'b00000;
        checks++;
        if ({count, op_vld, op_id_out, src_idx} !== {3'd1, 1'b1, 8'h77, 3'd1}) begin
            failures++;
            $display("FAIL mid_after got cnt=%0d vld=%b op=%h src=%0d exp cnt=1 vld=1 op=77 src=1",
                     count, op_vld, op_id_out, src_idx);
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_fill_overflow;
        test_multi_ack;
        test_full_rw;
        test_back_to_back;
        test_read_empty;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
